grid_scanner: RTL
=================

Name: grid_scanner

Overview:
- Reader side of the 64-bit Game of Life grid bus: consumes GridOut of the game and drives an 8x8 LED matrix one row at a time.
- Snapshots the grid at each frame start so the display never tears mid-frame.
- Inserts blanking between rows to suppress ghosting.
- Issues a periodic gen_step pulse that the top level uses to advance the game one generation.

Parameters:
- ROW_DWELL, 1000, clk cycles each row is driven (>=1)
- BLANK_CYCLES, 2, clk cycles of all-off between rows (>=0; 0 skips BLANK)
- FRAMES_PER_GEN, 60, full frames displayed per gen_step pulse (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- enable  input  1  start or continue scanning
- GridIn  input  64  live grid; row r = GridIn[8r+7:8r]; column c of row r = bit 8r+c
- row_sel  output  8  one-hot active-high row drive; bit r = row r
- col_data  output  8  active-high column data for the driven row
- frame_done  output  1  one-cycle pulse per completed frame
- gen_step  output  1  one-cycle pulse every FRAMES_PER_GEN frames
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; row, dwell and frame counters = 0; snapshot = 0.
  - All outputs = 0.
  - Reset mid-frame aborts the scan immediately; the next cycle shows all outputs 0.
- All outputs are registered. States: IDLE, LOAD, DRIVE, BLANK.
- IDLE: outputs 0. If enable=1, go to LOAD.
- LOAD (1 cycle):
  - snapshot <= GridIn; row <= 0; dwell <= 0.
  - row_sel=0, col_data=0.
  - Go to DRIVE.
- DRIVE:
  - row_sel = 1<<row; col_data = snapshot[8row+7:8row].
  - Lasts exactly ROW_DWELL cycles.
  - Then go to BLANK, or, if BLANK_CYCLES=0, go directly to row-advance.
- BLANK:
  - row_sel=0, col_data=0 for exactly BLANK_CYCLES cycles.
  - Then row-advance.
- Row-advance:
  - row<7: row++ and go to DRIVE. Row changes only here.
  - row=7 (frame end):
    - frame_done=1 for the next cycle only.
    - If frame counter = FRAMES_PER_GEN-1: gen_step=1 in that same cycle and the counter wraps to 0; otherwise the counter increments.
    - If enable=1, go to LOAD; otherwise go to IDLE.
- Frame period: 1 + 8*(ROW_DWELL+BLANK_CYCLES) cycles, back-to-back, with no idle gap while enable stays high.
- enable deassert mid-frame: the current frame completes with all pulses, then the block enters IDLE.
- Snapshot: GridIn is sampled only in LOAD. Changes to GridIn during DRIVE/BLANK have no visible effect until the next frame.
- Frame counter: not cleared by leaving IDLE; cleared only by reset.
- Counters:
  - dwell counter width = $clog2(max(ROW_DWELL, BLANK_CYCLES)+1).
  - frame counter width = $clog2(FRAMES_PER_GEN+1).
  - No counter overflows beyond its terminal value.
- FRAMES_PER_GEN=1: gen_step coincides with every frame_done.
- At most one row_sel bit is high in any cycle. row_sel=0 outside DRIVE.

Decomposition:
- Shared package (game_pkg):
  - GRID_W=64, GRID_ROWS=8, GRID_COLS=8.
  - typedef row_t = logic[7:0].
  - Enum scan_state_t {IDLE, LOAD, DRIVE, BLANK}.
  - Row-extraction function get_row(grid, r).
- One sub-module, dwell_counter:
  - Loadable down-counter with terminal-count output.
  - Reused for the DRIVE and BLANK durations.
- The frame counter and the FSM stay in grid_scanner.

Test Plan:
All scenarios use ROW_DWELL=4, BLANK_CYCLES=1, FRAMES_PER_GEN=2, giving a 41-cycle frame.
1. Reset hold with enable=1 and GridIn=all-ones -> all outputs 0, busy=0. First cycle after release -> LOAD; the DRIVE of row 0 starts 2 cycles after release.
2. GridIn=64'h8040201008040201 (diagonal) -> row r drives row_sel=1<<r with col_data=1<<r for 4 cycles, followed by 1 cycle of all-zero outputs; frame_done pulses 41 cycles after LOAD.
3. Continuous enable for 4 frames -> frame_done every 41 cycles; gen_step on frames 2 and 4 only, each exactly 1 cycle wide.
4. GridIn changed during the row-3 DRIVE -> rows 3-7 still show the old snapshot; the new value appears only after the next LOAD.
5. enable dropped during row 2 -> the frame finishes through row 7, frame_done pulses, then the block enters IDLE with busy=0 and row_sel=0.
6. reset_n asserted during row 5 DRIVE -> row_sel and col_data are 0 the next cycle. gen_step then fires only after 2 complete frames post-restart, since the frame counter was cleared.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the 64-bit Game of Life grid bus.
package game_pkg;

    localparam int GRID_W    = 64;
    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 8;

    typedef logic [GRID_COLS-1:0] row_t;

    typedef enum logic [1:0] {IDLE, LOAD, DRIVE, BLANK} scan_state_t;

    function automatic row_t get_row(input logic [GRID_W-1:0] grid, input logic [2:0] r);
        return grid[int'(r) * GRID_COLS +: GRID_COLS];
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter; tc is high while the count sits at zero.
module dwell_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/grid_scanner.sv
// Row-scanned 8x8 LED driver for the game grid, with per-frame snapshot,
// inter-row blanking and a generation-step pulse every FRAMES_PER_GEN frames.
module grid_scanner
    import game_pkg::*;
#(
    parameter int ROW_DWELL      = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int FRAMES_PER_GEN = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [63:0] GridIn,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic        gen_step,
    output logic        busy
);

    localparam int DWELL_MAX = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
    localparam int DW        = $clog2(DWELL_MAX + 1);
    localparam int FW        = $clog2(FRAMES_PER_GEN + 1);

    localparam logic [DW-1:0] DRIVE_LOAD = DW'(ROW_DWELL - 1);
    localparam logic [DW-1:0] BLANK_LOAD = DW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_GEN - 1);

    scan_state_t        state, stateNext;
    logic [2:0]         row, rowNext;
    logic [GRID_W-1:0]  snapshot, snapNext;
    logic [FW-1:0]      frameCnt, frameNext;
    logic               dwellLoad, dwellTc, advance;
    logic [DW-1:0]      dwellValue;
    row_t               rowSelNext, colNext;
    logic               doneNext, genNext, busyNext;

    dwell_counter #(.WIDTH(DW)) dwellCnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (dwellLoad),
        .loadValue (dwellValue),
        .tc        (dwellTc)
    );

    always_comb begin
        stateNext  = state;
        rowNext    = row;
        snapNext   = snapshot;
        frameNext  = frameCnt;
        dwellLoad  = 1'b0;
        dwellValue = DRIVE_LOAD;
        doneNext   = 1'b0;
        genNext    = 1'b0;
        advance    = 1'b0;

        case (state)
            IDLE:  if (enable) stateNext = LOAD;
            LOAD: begin
                snapNext  = GridIn;
                rowNext   = '0;
                dwellLoad = 1'b1;
                stateNext = DRIVE;
            end
            DRIVE: begin
                if (dwellTc) begin
                    if (BLANK_CYCLES > 0) begin
                        stateNext  = BLANK;
                        dwellLoad  = 1'b1;
                        dwellValue = BLANK_LOAD;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            BLANK: if (dwellTc) advance = 1'b1;
            default: stateNext = IDLE;
        endcase

        if (advance) begin
            if (row != 3'(GRID_ROWS - 1)) begin
                rowNext   = row + 3'd1;
                dwellLoad = 1'b1;
                stateNext = DRIVE;
            end else begin
                doneNext = 1'b1;
                if (frameCnt == FRAME_LAST) begin
                    genNext   = 1'b1;
                    frameNext = '0;
                end else begin
                    frameNext = frameCnt + FW'(1);
                end
                stateNext = enable ? LOAD : IDLE;
            end
        end

        // Outputs are derived from the next state so the registers line up with it.
        rowSelNext = (stateNext == DRIVE) ? (row_t'(1) << rowNext) : '0;
        colNext    = (stateNext == DRIVE) ? get_row(snapNext, rowNext) : '0;
        busyNext   = (stateNext != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            row        <= '0;
            snapshot   <= '0;
            frameCnt   <= '0;
            row_sel    <= '0;
            col_data   <= '0;
            frame_done <= 1'b0;
            gen_step   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= stateNext;
            row        <= rowNext;
            snapshot   <= snapNext;
            frameCnt   <= frameNext;
            row_sel    <= rowSelNext;
            col_data   <= colNext;
            frame_done <= doneNext;
            gen_step   <= genNext;
            busy       <= busyNext;
        end
    end

endmodule
